// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, no reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

    // Commit a write on the clock edge when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Combinational read of the addressed word.
    always_comb begin
        o_rdata = r_mem[i_addr];
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable wait states.
// Optional macro MEM_RESP_ALIGN_CHECK_EN: misaligned accesses skip the
// write and respond with rsp_err = 1, rsp_rdata = 0.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    mem_state_e        r_state;
    mem_state_e        w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_we;
    logic [AW-1:0]     r_idx;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_rdata;
    logic              r_err;

    logic              w_accept;
    logic              w_enter_resp;
    logic              w_cur_we;
    logic [AW-1:0]     w_cur_idx;
    logic [WORD_W-1:0] w_cur_wdata;
    logic              w_cur_mis;
    logic              w_mem_we;
    logic [WORD_W-1:0] w_mem_rdata;
    logic [ADDR_W-AW-1:0] w_unused_addr;

    assign w_unused_addr = {req_addr[ADDR_W-1:AW+2], req_addr[1:0]};

    assign req_ready    = (r_state == IDLE) && reset;
    assign w_accept     = req_valid && req_ready;
    assign w_enter_resp = (r_state != RESP) && (w_next == RESP);

    // With zero wait states RESP is entered on the accepting edge itself,
    // so commit/capture must use the live request rather than the latches.
    assign w_cur_we    = (r_state == IDLE) ? req_we            : r_we;
    assign w_cur_idx   = (r_state == IDLE) ? req_addr[AW+1:2]  : r_idx;
    assign w_cur_wdata = (r_state == IDLE) ? req_wdata         : r_wdata;

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic r_mis;
    logic w_in_mis;

    assign w_in_mis  = (req_addr[1:0] != 2'b00);
    assign w_cur_mis = (r_state == IDLE) ? w_in_mis : r_mis;

    // Latch the misalignment flag with the rest of the request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mis <= 1'b0;
        end else if (w_accept) begin
            r_mis <= w_in_mis;
        end
    end
`else
    assign w_cur_mis = 1'b0;
`endif

    assign w_mem_we = w_enter_resp && w_cur_we && !w_cur_mis;

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_mem_rdata)
    );

    // State and wait-counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_next = RESP;
                    end else begin
                        w_next     = WAIT;
                        w_cnt_next = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt <= 1) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the request fields on the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_idx   <= req_addr[AW+1:2];
            r_wdata <= req_wdata;
        end
    end

    // Capture response data and error flag on the edge entering RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (w_cur_we || w_cur_mis) ? '0 : w_mem_rdata;
            r_err   <= w_cur_mis;
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_CYCLES=2 and =0).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req_valid, b_req_valid;
    logic        a_req_ready, b_req_ready;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;
    logic        a_rsp_valid, b_rsp_valid;
    logic        rsp_ready;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic        a_rsp_err, b_rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access; called and returns at a negedge.
    // lat = index of the first negedge after acceptance showing rsp_valid.
    task automatic acc(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
        int n;
        req_we = we; req_addr = addr; req_wdata = wd;
        if (sel) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        n = 0;
        while (!(sel ? b_req_ready : a_req_ready) && n < 20) begin
            @(negedge clk); n++;
        end
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        lat = 1;
        while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
            @(negedge clk); lat++;
        end
        rd = sel ? b_rsp_rdata : a_rsp_rdata;
        er = sel ? b_rsp_err : a_rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          acc_at[$];
        int          n;

        reset = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = '0; req_wdata = '0;

        // Reset values while reset is held, even with a request pending
        repeat (3) @(negedge clk);
        a_req_valid = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, a_req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, a_rsp_err}, 32'd0);
        a_req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, a_req_ready}, 32'd1);

        // Write then read back, latency WAIT_CYCLES+1
        acc(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        chk("wr10_lat", lat, 32'd3);
        chk("wr10_rdata", rd, 32'd0);
        chk("wr10_err", {31'd0, er}, 32'd0);
        acc(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("rd10_lat", lat, 32'd3);
        chk("rd10_rdata", rd, 32'hDEADBEEF);

        // Address wrap modulo DEPTH_WORDS*4
        acc(1'b0, 1'b1, 32'h1000, 32'h1234, rd, er, lat);
        acc(1'b0, 1'b0, 32'h0000, 32'h0, rd, er, lat);
        chk("wrap_rdata", rd, 32'h1234);

        // Prior contents at 0x20, then abort a write by reset in WAIT
        acc(1'b0, 1'b1, 32'h20, 32'h11111111, rd, er, lat);
        acc(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5;
        a_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("abort_rsp_rdata", a_rsp_rdata, 32'd0);
        chk("abort_req_ready", {31'd0, a_req_ready}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        acc(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("abort_rd20", rd, 32'h11111111);

        // Misaligned write to 0x22
        acc(1'b0, 1'b1, 32'h22, 32'hCAFEF00D, rd, er, lat);
        chk("mis_lat", lat, 32'd3);
        chk("mis_rdata", rd, 32'd0);
        acc(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        chk("mis_err_on", {31'd0, er}, 32'd0);
        chk("mis_rd20_on", rd, 32'h11111111);
`else
        chk("mis_rd20_off", rd, 32'hCAFEF00D);
        chk("mis_rd_err_off", {31'd0, er}, 32'd0);
`endif
`ifdef MEM_RESP_ALIGN_CHECK_EN
        acc(1'b0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        chk("mis_rd_err_on", {31'd0, er}, 32'd1);
        chk("mis_rd_rdata_on", rd, 32'd0);
`endif

        // Back-to-back: req_valid and rsp_ready held high
        req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
        a_req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            if (a_req_ready) acc_at.push_back(i);
            @(negedge clk);
        end
        a_req_valid = 1'b0;
        n = 0;
        while (!a_req_ready && n < 10) begin
            @(negedge clk); n++;
        end
        rsp_ready = 1'b0;
        chk("b2b_count", acc_at.size(), 32'd6);
        for (int i = 1; i < 4; i++) begin
            if (i < acc_at.size())
                chk("b2b_gap", acc_at[i] - acc_at[i-1], 32'd4);
            else
                chk("b2b_gap_missing", 32'd0, 32'd4);
        end

        // WAIT_CYCLES=0 instance: write, then read with response stalled
        acc(1'b1, 1'b1, 32'h40, 32'h5A5A0001, rd, er, lat);
        chk("w0_wr_lat", lat, 32'd1);
        req_we = 1'b0; req_addr = 32'h40;
        b_req_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("w0_stall_valid", {31'd0, b_rsp_valid}, 32'd1);
            chk("w0_stall_rdata", b_rsp_rdata, 32'h5A5A0001);
            chk("w0_stall_ready", {31'd0, b_req_ready}, 32'd0);
        end
        b_req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("w0_after_valid", {31'd0, b_rsp_valid}, 32'd0);
        chk("w0_after_ready", {31'd0, b_req_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored; power of two, 16..65536.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before a response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  initiator consumes the response.
REQ-012 rsp_rdata  output  32  read data; 0 for writes.
REQ-013 rsp_err  output  1  misaligned-access flag, valid while rsp_valid is high.

Function
REQ-014 FSM states: IDLE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-015 A request is accepted on the rising edge where req_valid and req_ready are both 1; req_we, req_addr and req_wdata are latched at that edge.
REQ-016 On acceptance, the FSM goes IDLE->WAIT with the wait counter loaded to WAIT_CYCLES; when WAIT_CYCLES = 0 it goes IDLE->RESP directly.
REQ-017 In WAIT, the counter decrements once per cycle; on the edge where the counter equals 1, the FSM goes WAIT->RESP.
REQ-018 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-019 The write commit and the read-data capture both occur on the edge entering RESP.
REQ-020 A read after a write to the same word returns the new data.
REQ-021 In RESP: rsp_valid = 1, and rsp_rdata and rsp_err are held stable until the handshake edge.
REQ-022 The handshake edge is the edge where rsp_valid and rsp_ready are both 1; on it the FSM goes RESP->IDLE.
REQ-023 There is no acceptance in WAIT or RESP; the next request is accepted at the earliest one cycle after the handshake, giving a maximum throughput of one access per WAIT_CYCLES+2 cycles.
REQ-024 Word index = req_addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-025 req_valid held high while req_ready is 0 has no effect; a request dropped before acceptance is not recorded.
REQ-026 rsp_ready asserted outside RESP is ignored.

Reset
REQ-027 While reset is 0: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-028 While reset is 0, req_ready = 0; req_ready becomes 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted in WAIT aborts the access: an uncommitted write is discarded.
REQ-030 Storage contents are not cleared by reset.

Configuration
REQ-031 Macro MEM_RESP_ALIGN_CHECK_EN defined: an access with req_addr[1:0] != 0 performs no write and responds with rsp_err = 1 and rsp_rdata = 0, with unchanged latency.
REQ-032 Macro MEM_RESP_ALIGN_CHECK_EN undefined: req_addr[1:0] are ignored and rsp_err is tied to 0.

Structure
REQ-033 Shared package mem_pkg holds: the FSM state enumeration, WORD_W = 32, ADDR_W = 32, and the WAIT_CYCLES maximum constant (15).
REQ-034 The storage is the sub-module mem_array: synchronous write, combinational read, DEPTH_WORDS words of WORD_W bits.
REQ-035 The FSM, wait counter and response registers reside in mem_responder.

Verification
REQ-036 Reset, then write 0xDEADBEEF to 0x10, WAIT_CYCLES=2 -> rsp_valid high 3 cycles after acceptance, rsp_rdata=0; read 0x10 -> 0xDEADBEEF.
REQ-037 WAIT_CYCLES=0, read with rsp_ready held 0 for 4 cycles -> rsp_valid stays high, rsp_rdata stable, req_ready=0 throughout.
REQ-038 DEPTH_WORDS=1024, write 0x1234 to 0x1000, read 0x0000 -> returns 0x1234 (wrap-around).
REQ-039 Reset asserted 1 cycle after accepting a write of 0xA5A5A5A5 to 0x20 (WAIT_CYCLES=2) -> outputs at reset values; a later read of 0x20 returns the prior contents.
REQ-040 MEM_RESP_ALIGN_CHECK_EN defined, write to 0x22 -> rsp_err=1, word 0x20 unchanged; with the macro undefined -> word 0x20 written, rsp_err=0.
REQ-041 Back-to-back requests with req_valid held high -> acceptances spaced exactly WAIT_CYCLES+2 cycles apart when rsp_ready=1.
